apb_master: RTL and testbench

Single-outstanding APB bridge feeding the peripheral bus (GPIO, UART slaves). Accepts simple write/read requests over a valid/ready port from the system side, runs a compliant APB SETUP→ACCESS transfer on the decoded slave, honours PREADY wait states with a timeout, and returns one response per request. Sits directly upstream of the GPIO and UART APB slaves.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_decoder.sv | 26 ++
 rtl/apb_master.sv | 169 ++++++++++++++++
 tb/tb_apb_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB bridge and its peripheral map.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int DEC_BITS  = 4;
    localparam int GPIO_SLOT = 0;
    localparam int UART_SLOT = 1;

    localparam logic [7:0] GPIO_DATA = 8'h00;
    localparam logic [7:0] GPIO_DIR  = 8'h01;

endpackage

// File: rtl/apb_decoder.sv
// Address to one-hot slave select; the top DEC_BITS address bits choose the slot.
module apb_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int NUM_SLAVES = 2
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  dec_err
);

    logic [DEC_BITS-1:0] slot_s;

    assign slot_s  = addr[ADDR_W-1 -: DEC_BITS];
    assign dec_err = (int'(slot_s) >= NUM_SLAVES);

    // Out-of-range slots leave every select line low
    always_comb begin
        sel = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = (int'(slot_s) == i);
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding request/response to APB bridge with PREADY timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_t              state_r, state_s;
    logic [CNT_W-1:0]        wait_cnt_r, wait_cnt_s;
    logic [NUM_SLAVES-1:0]   dec_sel_s, psel_r, psel_s;
    logic                    dec_err_s;
    logic                    penable_r, penable_s, pwrite_r, pwrite_s;
    logic [ADDR_W-1:0]       paddr_r, paddr_s;
    logic [DATA_W-1:0]       pwdata_r, pwdata_s;
    logic                    rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s;
    logic [DATA_W-1:0]       rsp_rdata_r, rsp_rdata_s;
    logic                    req_ready_r, req_ready_s;
    logic                    slave_ready_s;
    logic [DATA_W-1:0]       slave_rdata_s;

    apb_decoder #(.ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES)) u_decoder (
        .addr    (req_addr),
        .sel     (dec_sel_s),
        .dec_err (dec_err_s)
    );

    // Ready and read data of the currently selected slave (PSEL is one-hot)
    always_comb begin
        slave_ready_s = 1'b0;
        slave_rdata_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slave_ready_s = slave_ready_s | (PREADY[i] & psel_r[i]);
            slave_rdata_s = slave_rdata_s | (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{psel_r[i]}});
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        psel_s      = psel_r;
        penable_s   = 1'b0;
        pwrite_s    = pwrite_r;
        paddr_s     = paddr_r;
        pwdata_s    = pwdata_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (req_valid && dec_err_s) begin
                    state_s     = RESP;
                    psel_s      = {NUM_SLAVES{1'b0}};
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                end else if (req_valid) begin
                    state_s    = SETUP;
                    wait_cnt_s = {CNT_W{1'b0}};
                    psel_s     = dec_sel_s;
                    pwrite_s   = req_write;
                    paddr_s    = req_addr;
                    pwdata_s   = req_wdata;
                end else begin
                    psel_s = {NUM_SLAVES{1'b0}};
                end
            end
            SETUP: begin
                state_s   = ACCESS;
                penable_s = 1'b1;
            end
            ACCESS: begin
                // A slave answering on the last allowed cycle still wins over the timeout
                if (slave_ready_s) begin
                    state_s     = RESP;
                    psel_s      = {NUM_SLAVES{1'b0}};
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = pwrite_r ? {DATA_W{1'b0}} : slave_rdata_s;
                end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_s     = RESP;
                    psel_s      = {NUM_SLAVES{1'b0}};
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                    penable_s  = 1'b1;
                end
            end
            RESP: begin
                state_s = IDLE;
                psel_s  = {NUM_SLAVES{1'b0}};
            end
            default: begin
                state_s = IDLE;
                psel_s  = {NUM_SLAVES{1'b0}};
            end
        endcase
        req_ready_s = (state_s == IDLE);
    end

    // State register and ACCESS wait counter
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r    <= IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Registered bus and response outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psel_r      <= {NUM_SLAVES{1'b0}};
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_W{1'b0}};
            pwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            req_ready_r <= 1'b1;
        end else begin
            psel_r      <= psel_s;
            penable_r   <= penable_s;
            pwrite_r    <= pwrite_s;
            paddr_r     <= paddr_s;
            pwdata_r    <= pwdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
            req_ready_r <= req_ready_s;
        end
    end

    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PADDR     = paddr_r;
    assign PWDATA    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign req_ready = req_ready_r;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized traffic vs a latency/response model.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NS = 2;
    localparam int TO = 16;

    logic          PCLK, PRESET;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [NS-1:0] PSEL, PREADY;
    logic          PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [NS*DW-1:0] PRDATA;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] prd_gpio, prd_uart;
    int            wait_target;
    int            acc_cnt;

    logic [1:0]    psel_log   [0:63];
    logic          pen_log    [0:63];
    logic          pwrite_log [0:63];
    logic [7:0]    paddr_log  [0:63];
    logic [7:0]    pwdata_log [0:63];

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model: the selected slave holds PREADY low for wait_target ACCESS cycles.
    // Unselected slaves always report ready, so a wrong-slot lookup shows up.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) acc_cnt <= 0;
        else if (PENABLE && (|PSEL)) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign PREADY = (PENABLE && acc_cnt >= wait_target) ? 2'b11 : ~PSEL;
    assign PRDATA = {prd_uart, prd_gpio};

    function automatic void model(input logic [7:0] addr, input logic wr, input int waits,
                                  output int lat, output logic err, output logic [7:0] rdata,
                                  output logic [1:0] sel);
        int slot;
        slot = int'(addr) / 16;
        sel  = (slot == GPIO_SLOT) ? 2'b01 : (slot == UART_SLOT) ? 2'b10 : 2'b00;
        if (slot >= NS) begin
            lat = 1; err = 1'b1; rdata = 8'h00;
        end else if (waits >= TO) begin
            lat = 2 + TO; err = 1'b1; rdata = 8'h00;
        end else begin
            lat = 3 + waits; err = 1'b0;
            rdata = wr ? 8'h00 : ((slot == GPIO_SLOT) ? prd_gpio : prd_uart);
        end
    endfunction

    // Issue one request at cycle 0 and log the bus until the response (cycle numbers from acceptance)
    task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wd, input int waits,
                          output int lat, output logic err, output logic [7:0] rd);
        int guard;
        guard = 0;
        wait_target = waits;
        @(negedge PCLK);
        while (req_ready !== 1'b1 && guard < 10) begin
            @(negedge PCLK);
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge PCLK);
        #1 req_valid = 1'b0;
        lat = -1; err = 1'bx; rd = 8'hxx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            psel_log[c] = PSEL; pen_log[c] = PENABLE; pwrite_log[c] = PWRITE;
            paddr_log[c] = PADDR; pwdata_log[c] = PWDATA;
            if (rsp_valid === 1'b1) begin
                lat = c; err = rsp_err; rd = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        prd_gpio = 8'h00; prd_uart = 8'h00; wait_target = 0;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_rsp got ready=%b valid=%b err=%b rdata=%h want 1 0 0 00",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (PSEL !== 2'b00 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 8'h00 || PWDATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_bus got psel=%b en=%b wr=%b addr=%h wdata=%h want all zero",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
    endtask

    task automatic test_write_zero_wait;
        int lat; logic err; logic [7:0] rd;
        do_txn(1'b1, GPIO_DIR, 8'hF0, 0, lat, err, rd);
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 8'h00) begin
            failures++;
            $display("FAIL wr0_rsp got lat=%0d err=%b rdata=%h want 3 0 00", lat, err, rd);
        end
        checks++;
        if (psel_log[1] !== 2'b01 || pen_log[1] !== 1'b0 || psel_log[2] !== 2'b01 || pen_log[2] !== 1'b1) begin
            failures++;
            $display("FAIL wr0_phases got c1 psel=%b en=%b c2 psel=%b en=%b want 01 0 01 1",
                     psel_log[1], pen_log[1], psel_log[2], pen_log[2]);
        end
        checks++;
        if (pwdata_log[1] !== 8'hF0 || pwdata_log[2] !== 8'hF0 || paddr_log[2] !== GPIO_DIR || pwrite_log[2] !== 1'b1) begin
            failures++;
            $display("FAIL wr0_stable got wdata=%h/%h addr=%h wr=%b want F0/F0 01 1",
                     pwdata_log[1], pwdata_log[2], paddr_log[2], pwrite_log[2]);
        end
    endtask

    task automatic test_read_wait;
        int lat; logic err; logic [7:0] rd; logic bad;
        prd_uart = 8'h5A; prd_gpio = 8'hA5;
        do_txn(1'b0, 8'h12, 8'h00, 3, lat, err, rd);
        checks++;
        if (lat !== 6 || err !== 1'b0 || rd !== 8'h5A) begin
            failures++;
            $display("FAIL rdwait_rsp got lat=%0d err=%b rdata=%h want 6 0 5a", lat, err, rd);
        end
        bad = 1'b0;
        for (int c = 1; c <= 5; c++) if (psel_log[c] !== 2'b10) bad = 1'b1;
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL rdwait_psel got psel c1..c5=%b %b %b %b %b want 10 throughout",
                     psel_log[1], psel_log[2], psel_log[3], psel_log[4], psel_log[5]);
        end
    endtask

    task automatic test_decode_error;
        int lat; logic err; logic [7:0] rd;
        prd_gpio = 8'h77; prd_uart = 8'h88;
        do_txn(1'b0, 8'h30, 8'h00, 0, lat, err, rd);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 8'h00 || psel_log[1] !== 2'b00) begin
            failures++;
            $display("FAIL decerr got lat=%0d err=%b rdata=%h psel=%b want 1 1 00 00", lat, err, rd, psel_log[1]);
        end
    endtask

    task automatic test_timeout;
        int lat; logic err; logic [7:0] rd;
        do_txn(1'b1, GPIO_DATA, 8'h3C, 1000, lat, err, rd);
        checks++;
        if (lat !== 2 + TO || err !== 1'b1 || rd !== 8'h00) begin
            failures++;
            $display("FAIL timeout got lat=%0d err=%b rdata=%h want %0d 1 00", lat, err, rd, 2 + TO);
        end
        do_txn(1'b1, GPIO_DATA, 8'h3C, TO - 1, lat, err, rd);
        checks++;
        if (lat !== 2 + TO || err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_lastready got lat=%0d err=%b want %0d 0", lat, err, 2 + TO);
        end
    endtask

    task automatic test_back_to_back;
        int acc2, r1, r2, guard;
        logic [7:0] pw2;
        acc2 = -1; r1 = -1; r2 = -1; pw2 = 8'hxx; guard = 0;
        wait_target = 0;
        @(negedge PCLK);
        while (req_ready !== 1'b1 && guard < 10) begin
            @(negedge PCLK);
            guard++;
        end
        req_valid = 1'b1; req_write = 1'b1; req_addr = GPIO_DATA; req_wdata = 8'hE3;
        @(posedge PCLK);
        #1 req_addr = GPIO_DIR; req_wdata = 8'h0F;
        for (int c = 1; c <= 20; c++) begin
            @(negedge PCLK);
            if (acc2 >= 0) req_valid = 1'b0;
            else if (req_ready === 1'b1) acc2 = c;
            if (acc2 >= 0 && c == acc2 + 1) pw2 = PWDATA;
            if (rsp_valid === 1'b1) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            if (r2 >= 0) break;
        end
        req_valid = 1'b0;
        checks++;
        if (r1 !== 3 || acc2 !== 4 || r2 !== 7) begin
            failures++;
            $display("FAIL b2b_timing got rsp1=%0d accept2=%0d rsp2=%0d want 3 4 7", r1, acc2, r2);
        end
        checks++;
        if (pw2 !== 8'h0F) begin
            failures++;
            $display("FAIL b2b_pwdata got %h want 0f", pw2);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic err; logic [7:0] rd; logic seen;
        wait_target = 1000;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h12; req_wdata = 8'h00;
        @(posedge PCLK);
        #1 req_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if (PENABLE !== 1'b1 || PSEL !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_access got psel=%b en=%b want 10 1", PSEL, PENABLE);
        end
        PRESET = 1'b1;
        #1;
        checks++;
        if (PSEL !== 2'b00 || PENABLE !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop got psel=%b en=%b want 00 0", PSEL, PENABLE);
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        PRESET = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_norsp got rsp_valid seen=%b want 0", seen);
        end
        do_txn(1'b1, GPIO_DIR, 8'h96, 0, lat, err, rd);
        checks++;
        if (lat !== 3 || err !== 1'b0 || pwdata_log[1] !== 8'h96) begin
            failures++;
            $display("FAIL rstmid_after got lat=%0d err=%b wdata=%h want 3 0 96", lat, err, pwdata_log[1]);
        end
    endtask

    task automatic test_random;
        int lat, exp_lat, w; logic err, exp_err, wr; logic [7:0] rd, exp_rd, addr, wd;
        logic [1:0] exp_sel, want_sel; logic want_en, bad;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 63));
            wd = 8'($urandom);
            w = $urandom_range(0, 20);
            prd_gpio = 8'($urandom);
            prd_uart = 8'($urandom);
            model(addr, wr, w, exp_lat, exp_err, exp_rd, exp_sel);
            do_txn(wr, addr, wd, w, lat, err, rd);
            checks++;
            if (lat !== exp_lat || err !== exp_err || rd !== exp_rd) begin
                failures++;
                $display("FAIL rand%0d_rsp addr=%h wr=%b waits=%0d got lat=%0d err=%b rdata=%h want %0d %b %h",
                         n, addr, wr, w, lat, err, rd, exp_lat, exp_err, exp_rd);
            end
            bad = 1'b0;
            for (int c = 1; c <= exp_lat; c++) begin
                want_sel = (c < exp_lat) ? exp_sel : 2'b00;
                want_en  = (exp_sel != 2'b00) && (c >= 2) && (c < exp_lat);
                if (psel_log[c] !== want_sel || pen_log[c] !== want_en) bad = 1'b1;
                if (exp_sel != 2'b00 && c < exp_lat &&
                    (paddr_log[c] !== addr || pwdata_log[c] !== wd || pwrite_log[c] !== wr)) bad = 1'b1;
            end
            checks++;
            if (bad !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_bus addr=%h wr=%b waits=%0d got c1 psel=%b en=%b addr=%h want psel=%b addr=%h",
                         n, addr, wr, w, psel_log[1], pen_log[1], paddr_log[1], exp_sel, addr);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_decode_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
